// File: rtl/cs_pkg.sv
// Shared definitions for the CS (9-tap approximate-average) computational system.
//   WIN     : window length of the CS datapath
//   X_W/Y_W : sample and result widths
//   state_e : run-controller sequencing states
package cs_pkg;

  localparam int unsigned WIN = 9;
  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/cs_run_ctrl_if.sv
// Bus bundle between the CS run controller and its surroundings.
//   start/busy/done          : run request and status
//   rd_en/rd_addr/rd_data    : sample memory read port (1-cycle latency)
//   cs_reset/cs_x/cs_y       : CS datapath clear, sample in, window average out
//   res_we/res_addr/res_data : result memory write port
// master : the run controller; slave : the system top (memories, CS, requester).
interface cs_run_ctrl_if import cs_pkg::*; #(
  parameter int unsigned ADDR_W = 6
);

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [X_W-1:0]    rd_data;
  logic              cs_reset;
  logic [X_W-1:0]    cs_x;
  logic [Y_W-1:0]    cs_y;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
  logic [Y_W-1:0]    res_data;

  modport master (
    input  start, rd_data, cs_y,
    output busy, done, rd_en, rd_addr, cs_reset, cs_x, res_we, res_addr, res_data
  );

  modport slave (
    output start, rd_data, cs_y,
    input  busy, done, rd_en, rd_addr, cs_reset, cs_x, res_we, res_addr, res_data
  );

endinterface

// File: rtl/cs_run_ctrl.sv
// Run sequencer for the CS datapath. On start it clears the CS window, streams
// N_SAMPLES samples from the sample memory into CS.X (one per cycle) and writes
// every full-window result CS.Y to the result memory.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : cs_run_ctrl_if master modport (start/busy/done, sample read port,
//           CS clear/X/Y, result write port)
module cs_run_ctrl import cs_pkg::*; #(
  parameter int unsigned N_SAMPLES = 64,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic          clk,
  input  logic          reset,
  cs_run_ctrl_if.master bus
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [CW-1:0] NCnt  = CW'(N_SAMPLES);
  localparam logic [CW-1:0] NLast = CW'(N_SAMPLES - 1);
  localparam logic [CW-1:0] WinTh = CW'(WIN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] wr_idx_q, wr_idx_d;
  logic          wr_vld_q, wr_vld_d;
  logic [CW-1:0] idx_nxt;
  logic          in_clr, in_feed, rd_more;

  assign idx_nxt = idx_q + CW'(1);
  assign in_clr  = (state_q == CLR);
  assign in_feed = (state_q == FEED);
  // Another read is due while the next sample index is still inside the run.
  assign rd_more = in_feed && (idx_nxt < NCnt);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_idx_d = idx_q;
    wr_vld_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = CLR;
      end
      CLR: begin
        idx_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        // Sample idx_q enters CS this cycle; its window is complete from index WIN-1 on.
        wr_vld_d = (idx_q >= WinTh);
        if (idx_q < NCnt) idx_d = idx_nxt;
        if (idx_q == NLast) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wr_idx_q <= '0;
      wr_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_idx_q <= wr_idx_d;
      wr_vld_q <= wr_vld_d;
    end
  end

  // Outputs are forced to their idle values while reset is held so an abort is
  // visible in the same cycle, not one edge later.
  always_comb begin
    bus.busy     = !reset && (state_q != IDLE);
    bus.done     = !reset && (state_q == DRAIN);
    bus.rd_en    = !reset && (in_clr || rd_more);
    bus.rd_addr  = '0;
    if (!reset && rd_more) bus.rd_addr = ADDR_W'(idx_nxt);
    bus.cs_reset = reset || in_clr;
    bus.cs_x     = (!reset && in_feed) ? bus.rd_data : '0;
    bus.res_we   = !reset && wr_vld_q;
    bus.res_addr = '0;
    if (!reset && wr_vld_q) bus.res_addr = ADDR_W'(wr_idx_q - WinTh);
    bus.res_data = bus.cs_y;
  end

endmodule
